fft_r4_ctrl: RTL and testbench
==============================

Name: fft_r4_ctrl

Overview:
- Sequencer for the radix-4 FFT processing element (pe).
- Runs an in-place N-point radix-4 DIF FFT over log4(N) stages.
- Per butterfly it issues 4 operand read addresses and one twiddle ROM address.
- It returns write-back addresses and write enable after the memory+PE pipeline latency, then reports completion.

Parameters:
- LOG4N, 3, number of radix-4 stages; N = 4**LOG4N (64 by default).
- ADDR_W, 2*LOG4N, data memory address width.
- TW_W, ADDR_W-2, twiddle ROM address width (exponent < N/4).
- STG_W, 2, stage counter width; must satisfy 2**STG_W >= LOG4N.
- PIPE_LAT, 2, cycles from rd_en to the matching write (sync RAM read 1 + PE output register 1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a transform; sampled in IDLE only
- busy  out  1  high from the first RUN cycle through the last DRAIN cycle
- done  out  1  one-cycle pulse after the final write of the last stage
- stage  out  STG_W  current stage index (0..LOG4N-1)
- rd_en  out  1  read strobe to the data memory
- rd_addr0..rd_addr3  out  ADDR_W each  operand addresses for pe in0..in3
- tw_addr  out  TW_W  twiddle ROM address (real and imaginary ROMs share it)
- wr_en  out  1  write strobe for pe out0..out3
- wr_addr0..wr_addr3  out  ADDR_W each  write-back addresses (in place)

Behaviour:
- Reset: state=IDLE. All counters, stage, rd_en, wr_en, busy and done are 0. All address outputs are 0. Reset is asynchronous assert, synchronous deassert at the next edge.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN with stage=0, b=0.
  - Otherwise stay in IDLE.
- RUN:
  - rd_en=1 every cycle.
  - Butterfly counter b runs 0..N/4-1, incrementing by 1 per cycle.
  - At b=N/4-1: go to DRAIN, and b wraps to 0.
- DRAIN:
  - rd_en=0 for exactly PIPE_LAT cycles, so the last write of a stage lands before the next stage reads (in-place RAW hazard).
  - Then, if stage<LOG4N-1: stage+1 and go to RUN.
  - Else go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Address generation (combinational from stage s and b, registered onto the outputs together with rd_en):
  - span = N >> 2(s+1)
  - g = b / span, k = b mod span
  - base = g*4*span + k
  - rd_addrm = base + m*span
  - tw_addr = k << 2s
  - All shifts are by constants derived from s. No divider: g and k are bit slices of b.
- Write path:
  - wr_en and wr_addr0..3 are rd_en and rd_addr0..3 delayed through a PIPE_LAT-deep shift register.
  - The shift register is cleared by reset.
- Timing:
  - With rd_en first high in cycle c1, stage s reads in cycles c1+s*(N/4+PIPE_LAT) for N/4 cycles.
  - done is high in cycle c1+LOG4N*(N/4+PIPE_LAT).
- Boundaries:
  - start while busy or in DONE is ignored (no queuing).
  - start held high re-triggers only after returning to IDLE.
  - Reset mid-transform aborts immediately: pending delayed writes are discarded and wr_en=0.
  - LOG4N=1 has a single stage; stage stays 0.

Decomposition:
- Package fft_pkg holds:
  - the FSM state encoding (IDLE/RUN/DRAIN/DONE as localparams);
  - LOG4N-derived constants N, ADDR_W, TW_W.
- Sub-module fft_r4_addr_gen: purely combinational (stage, b) -> rd_addr0..3 and tw_addr. It is reusable by a future multi-PE scheduler.
- The delay line stays inline.

Test Plan:
- Reset and idle: assert rst_n=0 mid-cycle -> all outputs 0 immediately. Hold start=0 for 10 cycles -> busy=0, rd_en=0.
- Stage 0 addressing (N=64): pulse start -> b=0 gives rd_addr={0,16,32,48}, tw=0. b=5 gives {5,21,37,53}, tw=5.
- Stage 1/2 addressing:
  - stage1, b=5 -> {17,21,25,29}, tw=4.
  - stage2, b=5 -> {20,21,22,23}, tw=0.
  - stage2, b=15 -> {60,61,62,63}, tw=0.
- Latency and count:
  - Each wr_en/wr_addr matches the rd_en/rd_addr of 2 cycles earlier.
  - Exactly 48 wr_en pulses occur.
  - done is high in cycle c1+54, one cycle wide; busy falls in the same cycle.
- Hazard: the last stage-0 write (cycle c1+17) precedes the first stage-1 read (cycle c1+18). The bench scoreboard verifies no address is read before its pending write.
- Start during busy and reset mid-run:
  - start pulsed at c1+10 -> ignored; total run length unchanged.
  - rst_n low at c1+20 -> state IDLE, wr_en=0 next edge.
  - A new start after release -> fresh sequence from stage 0, b=0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-4 FFT sequencer: FSM encoding and the
// default transform geometry derived from the number of radix-4 stages.
package fft_pkg;

  localparam int FFT_LOG4N  = 3;
  localparam int FFT_N      = 4 ** FFT_LOG4N;
  localparam int FFT_ADDR_W = 2 * FFT_LOG4N;
  localparam int FFT_TW_W   = FFT_ADDR_W - 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/fft_r4_addr_gen.sv
// Combinational radix-4 DIF address generator: maps (stage, butterfly index)
// onto the four in-place operand addresses and the twiddle exponent.
module fft_r4_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG4N  = FFT_LOG4N,
  parameter int ADDR_W = 2 * LOG4N,
  parameter int TW_W   = ADDR_W - 2,
  parameter int STG_W  = 2,
  parameter int B_W    = (TW_W > 0) ? TW_W : 1
) (
  input  logic [STG_W-1:0]  stage,
  input  logic [B_W-1:0]    b,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [ADDR_W-1:0] addr3,
  output logic [TW_W-1:0]   tw_addr
);

  int                sh;
  logic [B_W-1:0]    k;
  logic [ADDR_W-1:0] g_a;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] span;

  // span = 4**(LOG4N-1-s), so k and g are just the low/high bit fields of b
  always_comb begin
    sh = 2 * (LOG4N - 1) - 2 * int'(stage);
    if (sh < 0) sh = 0;
    k       = b & B_W'((1 << sh) - 1);
    g_a     = ADDR_W'(b) >> sh;
    base    = (g_a << (sh + 2)) | ADDR_W'(k);
    span    = ADDR_W'(1) << sh;
    addr0   = base;
    addr1   = base | span;
    addr2   = base | (span << 1);
    addr3   = base | span | (span << 1);
    tw_addr = TW_W'(k << (2 * int'(stage)));
  end

endmodule

// File: rtl/fft_r4_ctrl.sv
// Radix-4 FFT sequencer: walks all stages and butterflies, drives the operand
// reads and twiddle address, and replays them as in-place writes PIPE_LAT later.
module fft_r4_ctrl
  import fft_pkg::*;
#(
  parameter int LOG4N    = FFT_LOG4N,
  parameter int ADDR_W   = 2 * LOG4N,
  parameter int TW_W     = ADDR_W - 2,
  parameter int STG_W    = 2,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [STG_W-1:0]  stage,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic [ADDR_W-1:0] rd_addr3,
  output logic [TW_W-1:0]   tw_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [ADDR_W-1:0] wr_addr1,
  output logic [ADDR_W-1:0] wr_addr2,
  output logic [ADDR_W-1:0] wr_addr3
);

  localparam int N   = 4 ** LOG4N;
  localparam int B_W = (TW_W > 0) ? TW_W : 1;
  localparam int D_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [B_W-1:0]   B_LAST   = B_W'(N / 4 - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOG4N - 1);
  localparam logic [D_W-1:0]   D_LAST   = D_W'(PIPE_LAT - 1);

  fsm_state_t       st, st_nx;
  logic [B_W-1:0]   b, b_nx;
  logic [STG_W-1:0] stg, stg_nx;
  logic [D_W-1:0]   dcnt, dcnt_nx;
  logic             rd_nx, busy_nx, done_nx;

  logic [ADDR_W-1:0] ga0, ga1, ga2, ga3;
  logic [TW_W-1:0]   gtw;

  logic [PIPE_LAT-1:0]         en_p;
  logic [3:0][ADDR_W-1:0]      adr_p [PIPE_LAT];

  always_comb begin
    st_nx   = st;
    b_nx    = b;
    stg_nx  = stg;
    dcnt_nx = dcnt;
    case (st)
      S_IDLE: begin
        if (start) begin
          st_nx  = S_RUN;
          b_nx   = '0;
          stg_nx = '0;
        end
      end
      S_RUN: begin
        dcnt_nx = '0;
        if (b == B_LAST) begin
          st_nx = S_DRAIN;
          b_nx  = '0;
        end else begin
          b_nx = b + B_W'(1);
        end
      end
      S_DRAIN: begin
        // Reads stay off until the last in-place write of this stage has landed
        if (dcnt == D_LAST) begin
          dcnt_nx = '0;
          if (stg == STG_LAST) begin
            st_nx = S_DONE;
          end else begin
            stg_nx = stg + STG_W'(1);
            st_nx  = S_RUN;
          end
        end else begin
          dcnt_nx = dcnt + D_W'(1);
        end
      end
      S_DONE:  st_nx = S_IDLE;
      default: st_nx = S_IDLE;
    endcase
    rd_nx   = (st_nx == S_RUN);
    busy_nx = (st_nx == S_RUN) || (st_nx == S_DRAIN);
    done_nx = (st_nx == S_DONE);
  end

  // Addresses come from the next-state counters so they register alongside rd_en
  fft_r4_addr_gen #(
    .LOG4N  (LOG4N),
    .ADDR_W (ADDR_W),
    .TW_W   (TW_W),
    .STG_W  (STG_W),
    .B_W    (B_W)
  ) u_addr_gen (
    .stage   (stg_nx),
    .b       (b_nx),
    .addr0   (ga0),
    .addr1   (ga1),
    .addr2   (ga2),
    .addr3   (ga3),
    .tw_addr (gtw)
  );

  // Stage p0: FSM state and registered read-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      b        <= '0;
      stg      <= '0;
      dcnt     <= '0;
      rd_en    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_addr0 <= '0;
      rd_addr1 <= '0;
      rd_addr2 <= '0;
      rd_addr3 <= '0;
      tw_addr  <= '0;
    end else begin
      st       <= st_nx;
      b        <= b_nx;
      stg      <= stg_nx;
      dcnt     <= dcnt_nx;
      rd_en    <= rd_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      rd_addr0 <= rd_nx ? ga0 : '0;
      rd_addr1 <= rd_nx ? ga1 : '0;
      rd_addr2 <= rd_nx ? ga2 : '0;
      rd_addr3 <= rd_nx ? ga3 : '0;
      tw_addr  <= rd_nx ? gtw : '0;
    end
  end

  assign stage = stg;

  // Stage p1..pN: write-back delay line matching memory read + PE register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_p <= '0;
      for (int i = 0; i < PIPE_LAT; i++) adr_p[i] <= '0;
    end else begin
      en_p[0]  <= rd_en;
      adr_p[0] <= {rd_addr3, rd_addr2, rd_addr1, rd_addr0};
      for (int i = 1; i < PIPE_LAT; i++) begin
        en_p[i]  <= en_p[i-1];
        adr_p[i] <= adr_p[i-1];
      end
    end
  end

  assign wr_en    = en_p[PIPE_LAT-1];
  assign wr_addr0 = adr_p[PIPE_LAT-1][0];
  assign wr_addr1 = adr_p[PIPE_LAT-1][1];
  assign wr_addr2 = adr_p[PIPE_LAT-1][2];
  assign wr_addr3 = adr_p[PIPE_LAT-1][3];

endmodule

// File: tb/tb_fft_r4_ctrl.sv
// Scoreboard bench for fft_r4_ctrl (N=64): expected reads, writes, busy and
// done are queued at stimulus time and checked by an independent monitor.
module tb_fft_r4_ctrl;

  localparam int LOG4N    = 3;
  localparam int ADDR_W   = 6;
  localparam int TW_W     = 4;
  localparam int STG_W    = 2;
  localparam int PIPE_LAT = 2;
  localparam int NQ       = 16;
  localparam int RUNLEN   = NQ + PIPE_LAT;
  localparam int DONE_OFS = LOG4N * RUNLEN;
  localparam int BIG      = 1 << 30;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, rd_en, wr_en;
  logic [STG_W-1:0]  stage;
  logic [ADDR_W-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [ADDR_W-1:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;
  logic [TW_W-1:0]   tw_addr;

  fft_r4_ctrl #(
    .LOG4N(LOG4N), .ADDR_W(ADDR_W), .TW_W(TW_W), .STG_W(STG_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .stage(stage), .rd_en(rd_en),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .tw_addr(tw_addr), .wr_en(wr_en),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_addr3(wr_addr3)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int cyc; int stg; int a0; int a1; int a2; int a3; int tw;
  } rd_t;
  typedef struct packed {
    int cyc; int a0; int a1; int a2; int a3;
  } wr_t;

  rd_t rdq[$];
  rd_t spq[$];
  wr_t wrq[$];
  bit  exp_busy[1024];
  bit  exp_done[1024];
  int  pend[64];
  int  nwr = 0;
  int  cyc = 0;
  int  ntest = 0;
  int  nfail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    ntest++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Reference model: span/group/offset by plain division, no bit tricks
  task automatic push_run(input int c1, input int cut);
    rd_t r;
    wr_t w;
    int span, pw, g, k, base, rc;
    for (int s = 0; s < LOG4N; s++) begin
      span = NQ * 4;
      for (int i = 0; i <= s; i++) span = span / 4;
      pw = 1;
      for (int i = 0; i < s; i++) pw = pw * 4;
      for (int bb = 0; bb < NQ; bb++) begin
        g    = bb / span;
        k    = bb % span;
        base = g * 4 * span + k;
        rc   = c1 + s * RUNLEN + bb;
        r.cyc = rc; r.stg = s; r.tw = k * pw;
        r.a0 = base; r.a1 = base + span; r.a2 = base + 2 * span; r.a3 = base + 3 * span;
        if (rc < cut) rdq.push_back(r);
        w.cyc = rc + PIPE_LAT;
        w.a0 = r.a0; w.a1 = r.a1; w.a2 = r.a2; w.a3 = r.a3;
        if (rc + PIPE_LAT < cut) wrq.push_back(w);
      end
    end
    for (int c = c1; c < c1 + DONE_OFS && c < cut; c++) exp_busy[c] = 1'b1;
    if (c1 + DONE_OFS < cut) exp_done[c1 + DONE_OFS] = 1'b1;
  endtask

  task automatic push_spot(input int c, input int s, input int a0, input int a1,
                           input int a2, input int a3, input int tw);
    rd_t r;
    r.cyc = c; r.stg = s; r.a0 = a0; r.a1 = a1; r.a2 = a2; r.a3 = a3; r.tw = tw;
    spq.push_back(r);
  endtask

  task automatic push_spots(input int c1);
    push_spot(c1 + 0,  0,  0, 16, 32, 48, 0);
    push_spot(c1 + 5,  0,  5, 21, 37, 53, 5);
    push_spot(c1 + 23, 1, 17, 21, 25, 29, 4);
    push_spot(c1 + 41, 2, 20, 21, 22, 23, 0);
    push_spot(c1 + 51, 2, 60, 61, 62, 63, 0);
  endtask

  rd_t me, ms;
  wr_t mw;
  bit  er, ew;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) pend[i] = 0;
      nwr = 0;
    end
    er = (rdq.size() > 0) && (rdq[0].cyc == cyc);
    check("rd_en", int'(rd_en), int'(er));
    if (er) begin
      me = rdq.pop_front();
      if (rd_en) begin
        check("rd_stage", int'(stage), me.stg);
        check("rd_addr0", int'(rd_addr0), me.a0);
        check("rd_addr1", int'(rd_addr1), me.a1);
        check("rd_addr2", int'(rd_addr2), me.a2);
        check("rd_addr3", int'(rd_addr3), me.a3);
        check("tw_addr", int'(tw_addr), me.tw);
        check("raw_hazard0", pend[rd_addr0], 0);
        check("raw_hazard1", pend[rd_addr1], 0);
        check("raw_hazard2", pend[rd_addr2], 0);
        check("raw_hazard3", pend[rd_addr3], 0);
        pend[rd_addr0]++; pend[rd_addr1]++; pend[rd_addr2]++; pend[rd_addr3]++;
      end
    end
    ew = (wrq.size() > 0) && (wrq[0].cyc == cyc);
    check("wr_en", int'(wr_en), int'(ew));
    if (ew) begin
      mw = wrq.pop_front();
      if (wr_en) begin
        check("wr_addr0", int'(wr_addr0), mw.a0);
        check("wr_addr1", int'(wr_addr1), mw.a1);
        check("wr_addr2", int'(wr_addr2), mw.a2);
        check("wr_addr3", int'(wr_addr3), mw.a3);
        pend[wr_addr0]--; pend[wr_addr1]--; pend[wr_addr2]--; pend[wr_addr3]--;
      end
    end
    if (wr_en) nwr++;
    if ((spq.size() > 0) && (spq[0].cyc == cyc)) begin
      ms = spq.pop_front();
      check("spot_rd_en", int'(rd_en), 1);
      check("spot_stage", int'(stage), ms.stg);
      check("spot_addr0", int'(rd_addr0), ms.a0);
      check("spot_addr1", int'(rd_addr1), ms.a1);
      check("spot_addr2", int'(rd_addr2), ms.a2);
      check("spot_addr3", int'(rd_addr3), ms.a3);
      check("spot_tw", int'(tw_addr), ms.tw);
    end
    check("busy", int'(busy), int'(exp_busy[cyc]));
    check("done", int'(done), int'(exp_done[cyc]));
    if (done) begin
      check("wr_count", nwr, LOG4N * NQ);
      nwr = 0;
    end
  end

  int c1;

  initial begin
    // Reset held from time zero, then ten idle cycles with start low
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_wr_en", int'(wr_en), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Plain run
    start = 1'b1; c1 = cyc + 1;
    push_run(c1, BIG); push_spots(c1);
    @(negedge clk); start = 1'b0;
    repeat (60) @(negedge clk);

    // Start pulsed while busy is ignored
    start = 1'b1; c1 = cyc + 1;
    push_run(c1, BIG);
    @(negedge clk); start = 1'b0;
    while (cyc < c1 + 10) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (60) @(negedge clk);

    // Start held high re-triggers only once back in IDLE
    start = 1'b1; c1 = cyc + 1;
    push_run(c1, BIG);
    push_run(c1 + DONE_OFS + 2, BIG);
    while (cyc < c1 + DONE_OFS + 2) @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);

    // Asynchronous reset in the middle of stage 1
    start = 1'b1; c1 = cyc + 1;
    push_run(c1, c1 + 20);
    @(negedge clk); start = 1'b0;
    while (cyc < c1 + 19) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rd_en", int'(rd_en), 0);
    check("abort_wr_en", int'(wr_en), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_stage", int'(stage), 0);
    check("abort_rd_addr0", int'(rd_addr0), 0);
    check("abort_rd_addr3", int'(rd_addr3), 0);
    check("abort_wr_addr0", int'(wr_addr0), 0);
    check("abort_tw", int'(tw_addr), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Fresh transform after the abort
    start = 1'b1; c1 = cyc + 1;
    push_run(c1, BIG); push_spots(c1);
    @(negedge clk); start = 1'b0;
    repeat (60) @(negedge clk);

    check("rd_queue_left", rdq.size(), 0);
    check("wr_queue_left", wrq.size(), 0);
    check("spot_queue_left", spq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
